imem_loader: RTL



---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot loader and the instruction-memory write port.
// IMEM_DATA_W is also used by the CPU top for the read side.
package imem_loader_pkg;

  localparam int IMEM_DATA_W = 16;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream boot loader: SYNC, 16-bit length, big-endian words, XOR checksum.
// Writes words into instruction memory and holds the CPU in reset until verified.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | waiting for SYNC, other bytes dropped
// ST_LEN_HI  | next byte is the length high byte
// ST_LEN_LO  | next byte is the length low byte, length range check
// ST_DATA_HI | next byte is a word high byte
// ST_DATA_LO | next byte is a word low byte, write issued the following cycle
// ST_CHK     | next byte is the checksum
// ST_DONE    | image verified, CPU released, SYNC restarts a load
// ST_ERR     | frame rejected, CPU held, SYNC restarts a load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [7:0]             i_RxData,
  input  logic                   i_RxValid,
  output logic                   o_RxReady,
  output logic                   o_WrEn,
  output logic [ADDR_W-1:0]      o_WrAddr,
  output logic [IMEM_DATA_W-1:0] o_WrData,
  output logic                   o_CpuRst,
  output logic                   o_Done,
  output logic                   o_Err
);

  // Largest legal length; compared in 17 bits so 2^ADDR_W itself is representable.
  localparam logic [16:0]     LEN_MAX = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  loader_state_e state_q, state_d;
  logic [ADDR_W:0]          cnt_q, cnt_d;
  logic [15:0]              len_q, len_d;
  logic [7:0]               hi_q, hi_d;
  logic [7:0]               chk_q, chk_d;
  logic                     rx_ready_q, rx_ready_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [IMEM_DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                     cpu_rst_q, cpu_rst_d;
  logic                     done_q, done_d;
  logic                     err_q, err_d;

  logic              accept;
  logic [7:0]        chk_upd;
  logic [15:0]       len_new;
  logic [ADDR_W:0]   cnt_inc;

  assign accept  = i_RxValid && rx_ready_q;
  assign chk_upd = chk_q ^ i_RxData;
  assign len_new = {len_q[15:8], i_RxData};
  assign cnt_inc = cnt_q + CNT_ONE;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      hi_q       <= '0;
      chk_q      <= '0;
      rx_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      hi_q       <= hi_d;
      chk_q      <= chk_d;
      rx_ready_q <= rx_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    hi_d       = hi_q;
    chk_d      = chk_q;
    rx_ready_d = 1'b1;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cpu_rst_d  = cpu_rst_q;
    done_d     = done_q;
    err_d      = err_q;

    if (accept) begin
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (i_RxData == SYNC_BYTE) begin
            state_d   = ST_LEN_HI;
            cnt_d     = '0;
            chk_d     = '0;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            err_d     = 1'b0;
          end
        end
        ST_LEN_HI: begin
          len_d[15:8] = i_RxData;
          chk_d       = chk_upd;
          state_d     = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d = len_new;
          chk_d = chk_upd;
          if (len_new == 16'd0) begin
            state_d = ST_CHK;
          end else if ({1'b0, len_new} > LEN_MAX) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = ST_DATA_HI;
          end
        end
        ST_DATA_HI: begin
          hi_d    = i_RxData;
          chk_d   = chk_upd;
          state_d = ST_DATA_LO;
        end
        ST_DATA_LO: begin
          chk_d     = chk_upd;
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = {hi_q, i_RxData};
          cnt_d     = cnt_inc;
          state_d   = (16'(cnt_inc) == len_q) ? ST_CHK : ST_DATA_HI;
        end
        ST_CHK: begin
          chk_d = chk_upd;
          if (i_RxData == chk_q) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign o_RxReady = rx_ready_q;
  assign o_WrEn    = wr_en_q;
  assign o_WrAddr  = wr_addr_q;
  assign o_WrData  = wr_data_q;
  assign o_CpuRst  = cpu_rst_q;
  assign o_Done    = done_q;
  assign o_Err     = err_q;

endmodule
